imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder for the fetch port: the memory end of the `fe_req`/`fe_addr`/`fe_ack`/`fe_data` handshake driven by the fetch stage.
- Holds a word-organised instruction store, preloaded through a loader write port.
- Acknowledges fetch requests after a programmable number of wait states.
- Returns the instruction word registered in the cycle after the acknowledge, and holds it stable until the next acknowledge, so decode can sample it across stalls.

## Interface
- `DEPTH_WORDS`, 4096 — number of 32-bit words in the store; power of two.
- `BASE_ADDR`, 32'h80000000 — byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `WAIT_STATES`, 2 — cycles between request presentation and acknowledge; 0..15. Used only when `IMEM_WAIT_EN` is defined.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `fe_req`  in  1  fetch request, level; may drop or change address any cycle.
- `fe_addr`  in  32  fetch byte address; bits [1:0] ignored.
- `fe_ack`  out  1  combinational; request accepted this cycle.
- `fe_data`  out  32  registered instruction word for the last accepted request.
- `ld_we`  in  1  loader write enable.
- `ld_addr`  in  32  loader byte address; bits [1:0] ignored; same window as fetch.
- `ld_data`  in  32  loader write data.
- `oob_err`  out  1  sticky; an accepted fetch or loader write fell outside the window.

## Operation
- Word index: `(addr - BASE_ADDR) >> 2`, modulo 2^32.
  - In range iff the index is below `DEPTH_WORDS`.
  - Out-of-range fetch: accepted normally; `fe_data` = 32'h00000000 (illegal instruction, so decode traps); `oob_err` sets.
  - Out-of-range loader write: dropped; `oob_err` sets.
- Data capture:
  - On the rising edge ending an `fe_ack` cycle: `fe_data <= mem[index]`, or 0 if out of range.
  - Otherwise `fe_data` holds.
- Loader write: on the edge with `ld_we`=1, `mem[index] <= ld_data`.
  - Same edge as a fetch capture of the same word: the fetch returns the old contents (read-before-write).
- State machine, compiled only with `IMEM_WAIT_EN`; registers `state`, `cnt[3:0]`, `lat_idx`.
  - IDLE, `fe_req`=1, `WAIT_STATES`=0: `fe_ack`=1 this cycle; stay in IDLE.
  - IDLE, `fe_req`=1, `WAIT_STATES`>0: `fe_ack`=0; latch the index; `cnt <= WAIT_STATES-1`; go to WAIT.
  - WAIT, `fe_req`=0: abandon the request; go to IDLE; `fe_data` untouched.
  - WAIT, index != `lat_idx` (redirect): re-latch the index; `cnt <= WAIT_STATES-1`; stay in WAIT.
  - WAIT, same index, `cnt`!=0: decrement `cnt`.
  - WAIT, same index, `cnt`==0: `fe_ack`=1; go to IDLE.
- A request held high after its acknowledge is a new request and pays the full wait again.
- Reset, including mid-WAIT: state IDLE, `cnt`=0, `fe_data`=0, `oob_err`=0, `fe_ack`=0 while reset is asserted. Memory contents are not reset.

## Timing
- Request first presented in IDLE at cycle T: `fe_ack` in cycle T+N (N = effective wait states); `fe_data` valid from T+N+1.
- `fe_data` stays valid until the edge after the next `fe_ack`.
- Throughput:
  - One word per cycle when N=0.
  - One word per N+1 cycles otherwise.
- Redirect at cycle R in WAIT: `fe_ack` at R+N for the new address; the old address is never acknowledged.
- `fe_ack` depends combinationally on `fe_req` and `fe_addr`. There is no combinational path from `ld_*` to any output.

## Configuration
- `IMEM_WAIT_EN` defined: the wait-state machine is built and `WAIT_STATES` applies.
- `IMEM_WAIT_EN` undefined:
  - No state machine or counter.
  - `fe_ack = fe_req & reset_n`.
  - Single-cycle fetch regardless of `WAIT_STATES`.

## Test plan
- Zero-wait, back-to-back fetch:
  - Build without the macro; load words 0..3 with 0x11111111..0x44444444.
  - Stimulus: `fe_req` high with `fe_addr` 0x80000000, 0x80000004, 0x80000008 on consecutive cycles.
  - Required: `fe_ack` high in every cycle; `fe_data` = 0x11111111, 0x22222222, 0x33333333 one cycle later each.
- Wait states:
  - `IMEM_WAIT_EN`, `WAIT_STATES`=2.
  - Stimulus: request 0x80000004 from cycle 10.
  - Required: `fe_ack` only in cycle 12; `fe_data` = 0x22222222 from cycle 13 and held through 10 idle cycles.
- Redirect mid-wait:
  - `WAIT_STATES`=3.
  - Stimulus: request 0x80000000 at cycle 0; address changes to 0x80000008 at cycle 2.
  - Required: no ack for 0x80000000; `fe_ack` at cycle 5; `fe_data` = 0x33333333 from cycle 6.
- Request drop and reset:
  - Stimulus 1: `fe_req` falls in WAIT. Required: state returns to IDLE; no ack; `fe_data` unchanged.
  - Stimulus 2: `reset_n` low for one cycle in WAIT. Required: `fe_data`=0 and IDLE after the reset edge.
- Out of range:
  - Stimulus: fetch at 0x80004000 with `DEPTH_WORDS`=4096.
  - Required: acknowledged; `fe_data`=0; `oob_err`=1 and stays 1 until reset.
- Load/fetch collision:
  - Stimulus: `ld_we` writes 0xDEADBEEF to 0x80000000 on the same edge as a fetch capture of that word.
  - Required: that fetch returns the old word; the next fetch of 0x80000000 returns 0xDEADBEEF.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch port: word store with loader port and registered fetch data.
// Define IMEM_WAIT_EN to build the programmable wait-state machine; otherwise every request is acked at once.
module imem_responder #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fe_req,
   input  logic [31:0] fe_addr,
   output logic        fe_ack,
   output logic [31:0] fe_data,
   input  logic        ld_we,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data,
   output logic        oob_err
);

   localparam int unsigned AW      = $clog2(DEPTH_WORDS);
   localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);

   // BASE_ADDR is aligned, so (addr - BASE) >> 2 reduces to a word-field subtraction.
   logic [29:0] fe_idx;
   logic [29:0] ld_idx;
   logic        fe_in_range;
   logic        ld_in_range;
   logic        unused_byte_bits;

   assign fe_idx           = fe_addr[31:2] - BASE_ADDR[31:2];
   assign ld_idx           = ld_addr[31:2] - BASE_ADDR[31:2];
   assign fe_in_range      = (fe_idx < DEPTH_L);
   assign ld_in_range      = (ld_idx < DEPTH_L);
   assign unused_byte_bits = ^{fe_addr[1:0], ld_addr[1:0]};

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] fe_data_q;
   logic        oob_err_q;

`ifdef IMEM_WAIT_EN
   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [29:0] lat_idx_q, lat_idx_d;
   logic        ack_raw;

   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lat_idx_d = lat_idx_q;
      ack_raw   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fe_req) begin
               if (WAIT_STATES == 0) begin
                  ack_raw = 1'b1;
               end else begin
                  lat_idx_d = fe_idx;
                  cnt_d     = CNT_INIT;
                  state_d   = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!fe_req) begin
               state_d = S_IDLE;
            end else if (fe_idx != lat_idx_q) begin
               // Redirect: the new address restarts the full wait.
               lat_idx_d = fe_idx;
               cnt_d     = CNT_INIT;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               ack_raw = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         lat_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lat_idx_q <= lat_idx_d;
      end
   end

   assign fe_ack = ack_raw & reset_n;
`else
   assign fe_ack = fe_req & reset_n;
`endif

   // Reads here see the pre-edge contents, which gives read-before-write on a collision.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fe_data_q <= '0;
         oob_err_q <= 1'b0;
      end else begin
         if (fe_ack) begin
            fe_data_q <= fe_in_range ? mem[fe_idx[AW-1:0]] : 32'h0000_0000;
         end
         if ((fe_ack && !fe_in_range) || (ld_we && !ld_in_range)) begin
            oob_err_q <= 1'b1;
         end
      end
   end

   // NOTE: the store has no reset so it maps onto block RAM; contents survive reset_n.
   always_ff @(posedge clk) begin
      if (ld_we && ld_in_range) begin
         mem[ld_idx[AW-1:0]] <= ld_data;
      end
   end

   assign fe_data = fe_data_q;
   assign oob_err = oob_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: table-driven fetches, corner sequences and random traffic vs a model.
module tb_imem_responder;

   localparam int unsigned DEPTH = 4096;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int unsigned WS    = 2;
`ifdef IMEM_WAIT_EN
   localparam int N_EFF = int'(WS);
`else
   localparam int N_EFF = 0;
`endif

   logic        clk;
   logic        reset_n;
   logic        fe_req;
   logic [31:0] fe_addr;
   logic        fe_ack;
   logic [31:0] fe_data;
   logic        ld_we;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        oob_err;

   imem_responder #(
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR  (BASE),
      .WAIT_STATES(WS)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .fe_req (fe_req),
      .fe_addr(fe_addr),
      .fe_ack (fe_ack),
      .fe_data(fe_data),
      .ld_we  (ld_we),
      .ld_addr(ld_addr),
      .ld_data(ld_data),
      .oob_err(oob_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: memory image, expected outputs, and age of the pending request.
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_data;
   logic        m_oob;
   bit          pend;
   logic [31:0] pend_idx;
   int          age;
   bit          last_ack;

   function automatic logic [31:0] word_idx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off >> 2;
   endfunction

   // One clock cycle: drive inputs, check ack mid-cycle, apply model at the edge, check registers after it.
   task automatic cycle(input logic req, input logic [31:0] addr, input logic we,
                        input logic [31:0] la, input logic [31:0] ld);
      logic [31:0] idx;
      logic [31:0] lidx;
      bit          exp_ack;
      fe_req  = req;
      fe_addr = addr;
      ld_we   = we;
      ld_addr = la;
      ld_data = ld;
      idx     = word_idx(addr);
      lidx    = word_idx(la);
      exp_ack = 1'b0;
      if (!req) begin
         pend = 1'b0;
      end else begin
         if (pend && idx == pend_idx) begin
            age++;
         end else begin
            pend     = 1'b1;
            pend_idx = idx;
            age      = 0;
         end
         if (age == N_EFF) begin
            exp_ack = 1'b1;
            pend    = 1'b0;
         end
      end
      @(negedge clk);
      check("fe_ack", {31'd0, fe_ack}, {31'd0, exp_ack});
      @(posedge clk);
      if (exp_ack) begin
         if (idx < DEPTH) m_data = m_mem[idx[11:0]];
         else begin
            m_data = 32'h0;
            m_oob  = 1'b1;
         end
      end
      if (we) begin
         if (lidx < DEPTH) m_mem[lidx[11:0]] = ld;
         else m_oob = 1'b1;
      end
      last_ack = exp_ack;
      #1;
      check("fe_data", fe_data, m_data);
      check("oob_err", {31'd0, oob_err}, {31'd0, m_oob});
   endtask

   task automatic do_reset(input logic req);
      reset_n = 1'b0;
      fe_req  = req;
      fe_addr = BASE;
      ld_we   = 1'b0;
      @(negedge clk);
      check("ack_in_reset", {31'd0, fe_ack}, 32'd0);
      @(posedge clk);
      m_data   = 32'h0;
      m_oob    = 1'b0;
      pend     = 1'b0;
      last_ack = 1'b0;
      #1;
      reset_n = 1'b1;
      check("data_after_reset", fe_data, 32'h0);
      check("oob_after_reset", {31'd0, oob_err}, 32'd0);
   endtask

   // Hold a request until acknowledged (bounded); returns cycles taken including the ack cycle.
   task automatic fetch_hold(input logic [31:0] addr, output int lat);
      lat = 0;
      last_ack = 1'b0;
      for (int k = 0; k < N_EFF + 4; k++) begin
         cycle(1'b1, addr, 1'b0, 32'h0, 32'h0);
         lat++;
         if (last_ack) break;
      end
      check("fetch_ack_seen", {31'd0, last_ack}, 32'd1);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        oob;
   } vec_t;

   vec_t vec [6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat;
      logic [31:0] cur_addr;
      logic        rq;
      logic        we;
      logic [31:0] la;

      vec[0] = '{BASE,                32'h1111_1111, 1'b0};
      vec[1] = '{BASE + 32'h4,        32'h2222_2222, 1'b0};
      vec[2] = '{BASE + 32'h8,        32'h3333_3333, 1'b0};
      vec[3] = '{BASE + 32'hC,        32'h4444_4444, 1'b0};
      vec[4] = '{BASE + 32'h4000,     32'h0000_0000, 1'b1};
      vec[5] = '{BASE + 32'hB,        32'h3333_3333, 1'b1};

      reset_n = 1'b0;
      fe_req  = 1'b0;
      fe_addr = '0;
      ld_we   = 1'b0;
      ld_addr = '0;
      ld_data = '0;
      m_data  = '0;
      m_oob   = 1'b0;
      pend    = 1'b0;
      pend_idx = '0;
      age     = 0;
      last_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset(1'b1);

      for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, vec[i].addr, vec[i].data);

      // Back-to-back fetches, including an out-of-range one that makes oob_err sticky.
      for (int i = 0; i < 6; i++) begin
         fetch_hold(vec[i].addr, lat);
         check("vec_data", fe_data, vec[i].data);
         check("vec_oob", {31'd0, oob_err}, {31'd0, vec[i].oob});
         check("vec_latency", lat, N_EFF + 1);
      end

      do_reset(1'b0);

      // Loader write colliding with a fetch capture of the same word.
      cycle(1'b0, BASE, 1'b0, 32'h0, 32'h0);
      for (int k = 0; k <= N_EFF; k++)
         cycle(1'b1, BASE, (k == N_EFF), BASE, 32'hDEAD_BEEF);
      check("collide_old", fe_data, 32'h1111_1111);
      fetch_hold(BASE, lat);
      check("collide_new", fe_data, 32'hDEAD_BEEF);
      for (int k = 0; k < 10; k++) cycle(1'b0, BASE + 32'h4, 1'b0, 32'h0, 32'h0);
      check("hold_idle", fe_data, 32'hDEAD_BEEF);

`ifdef IMEM_WAIT_EN
      // Redirect mid-wait: the first address is never acknowledged.
      cycle(1'b1, BASE, 1'b0, 32'h0, 32'h0);
      cycle(1'b1, BASE, 1'b0, 32'h0, 32'h0);
      fetch_hold(BASE + 32'h8, lat);
      check("redirect_lat", lat, N_EFF + 1);
      check("redirect_data", fe_data, 32'h3333_3333);

      // Request dropped in WAIT: no ack, data untouched, next request pays full wait.
      cycle(1'b1, BASE + 32'h4, 1'b0, 32'h0, 32'h0);
      cycle(1'b0, BASE + 32'h4, 1'b0, 32'h0, 32'h0);
      check("drop_data", fe_data, 32'h3333_3333);
      fetch_hold(BASE + 32'h4, lat);
      check("drop_refetch_lat", lat, N_EFF + 1);
      check("drop_refetch_data", fe_data, 32'h2222_2222);

      // Reset in WAIT returns to IDLE.
      cycle(1'b1, BASE + 32'h4, 1'b0, 32'h0, 32'h0);
      do_reset(1'b1);
      fetch_hold(BASE + 32'hC, lat);
      check("reset_refetch_lat", lat, N_EFF + 1);
      check("reset_refetch_data", fe_data, 32'h4444_4444);
`endif

      for (int i = 0; i < 16; i++) cycle(1'b0, 32'h0, 1'b1, BASE + 32'(i * 4), $urandom);

      cur_addr = BASE;
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(3) == 0) begin
            case ($urandom_range(15))
               0:       cur_addr = BASE + 32'h4000 + ($urandom_range(255) << 2);
               1:       cur_addr = BASE - 32'h4;
               default: cur_addr = BASE + ($urandom_range(15) << 2) + $urandom_range(3);
            endcase
         end
         rq = ($urandom_range(4) != 0);
         we = ($urandom_range(7) == 0);
         la = ($urandom_range(15) == 0) ? BASE + 32'h8000 : BASE + ($urandom_range(15) << 2);
         if ($urandom_range(199) == 0) do_reset(rq);
         else cycle(rq, cur_addr, we, la, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
